// File: rtl/dmem_miss_ctrl.sv
// Data-cache miss sequencer for the MEM stage: freezes the upstream pipeline, bubbles MEM/WB,
// requests and waits for a refill, strobes the cache write, counts misses and traps timeouts.
module dmem_miss_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MemAccessM,
  input  logic                 HitM,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 RefillEn,
  output logic                 StallM,
  output logic                 BubbleW,
  output logic [CNT_WIDTH-1:0] MissCount,
  output logic                 TimeoutErr
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MISS_REQ  = 3'd1,
    S_MISS_WAIT = 3'd2,
    S_REFILL    = 3'd3,
    S_ERROR     = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [WAIT_W-1:0]     w_wait_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_miss_cnt;
  logic                  w_miss;
  logic                  w_miss_cnt_sat;
  logic                  w_count_miss;

  assign w_miss         = MemAccessM & ~HitM;
  assign w_miss_cnt_sat = &r_miss_cnt;
  assign w_count_miss   = (r_state == S_IDLE) & w_miss & ~w_miss_cnt_sat;

  // State, wait counter and saturating miss counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_count_miss) begin
        r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Next-state and state-decoded outputs; everything forced low while rst is asserted
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    mem_req        = 1'b0;
    RefillEn       = 1'b0;
    StallM         = 1'b0;
    TimeoutErr     = 1'b0;

    case (r_state)
      S_IDLE: begin
        StallM = w_miss;
        if (w_miss) begin
          w_state_nxt = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_req = 1'b1;
        StallM  = 1'b1;
        if (mem_ready) begin
          w_state_nxt = S_REFILL;
        end else begin
          w_state_nxt    = S_MISS_WAIT;
          w_wait_cnt_nxt = '0;
        end
      end
      S_MISS_WAIT: begin
        StallM         = 1'b1;
        w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        // A refill arriving on the last allowed cycle still wins over the timeout
        if (mem_ready) begin
          w_state_nxt = S_REFILL;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_REFILL: begin
        RefillEn    = 1'b1;
        StallM      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERROR: begin
        StallM     = 1'b1;
        TimeoutErr = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (rst) begin
      mem_req    = 1'b0;
      RefillEn   = 1'b0;
      StallM     = 1'b0;
      TimeoutErr = 1'b0;
    end
  end

  assign BubbleW   = StallM;
  assign MissCount = rst ? '0 : r_miss_cnt;

endmodule

// File: tb/tb_dmem_miss_ctrl.sv
// Directed bench for dmem_miss_ctrl with a short timeout and a narrow miss counter.
module tb_dmem_miss_ctrl;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ma;
  logic          hit;
  logic          rdy;
  logic          mem_req;
  logic          RefillEn;
  logic          StallM;
  logic          BubbleW;
  logic [CW-1:0] MissCount;
  logic          TimeoutErr;

  dmem_miss_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemAccessM (ma),
    .HitM       (hit),
    .mem_ready  (rdy),
    .mem_req    (mem_req),
    .RefillEn   (RefillEn),
    .StallM     (StallM),
    .BubbleW    (BubbleW),
    .MissCount  (MissCount),
    .TimeoutErr (TimeoutErr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stall, n_req, n_refill, n_terr, n_bub, cyc_idx, req_at, refill_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_stall = 0; n_req = 0; n_refill = 0; n_terr = 0; n_bub = 0;
    cyc_idx = 0; req_at = 0; refill_at = 0;
  endtask

  // One clock cycle: drive inputs, sample outputs mid-cycle, then advance past the edge
  task automatic cyc(input logic a, input logic h, input logic r);
    ma = a; hit = h; rdy = r;
    #2;
    cyc_idx++;
    if (StallM === 1'b1) n_stall++;
    if (TimeoutErr === 1'b1) n_terr++;
    if (BubbleW !== StallM) n_bub++;
    if (mem_req === 1'b1) begin n_req++; req_at = cyc_idx; end
    if (RefillEn === 1'b1) begin n_refill++; refill_at = cyc_idx; end
    @(posedge clk);
    #1;
  endtask

  task automatic miss_fast();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ma = 1'b0; hit = 1'b0; rdy = 1'b0;
    @(posedge clk);
    #1;
    clr();
    cyc(1'b1, 1'b0, 1'b0);
    check("reset_cycle_stall", 32'(n_stall), 32'd0);
    rst = 1'b0;
    ma = 1'b0; hit = 1'b0; rdy = 1'b0;
    #2;
    check("post_reset_stall", 32'(StallM), 32'd0);
    check("post_reset_count", 32'(MissCount), 32'd0);
    check("post_reset_terr", 32'(TimeoutErr), 32'd0);
    @(posedge clk);
    #1;

    // Hits only
    clr();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    check("hit_stall", 32'(n_stall), 32'd0);
    check("hit_req", 32'(n_req), 32'd0);
    check("hit_count", 32'(MissCount), 32'd0);

    // Miss with four wait cycles, ready on the fourth
    clr();
    ma = 1'b1; hit = 1'b0; rdy = 1'b0;
    #1;
    check("miss_comb_stall", 32'(StallM), 32'd1);
    #1;
    @(posedge clk);
    #1;
    clr();
    ma = 1'b0;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    clr();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("w4_stall_cycles", 32'(n_stall), 32'd7);
    check("w4_req_pulses", 32'(n_req), 32'd1);
    check("w4_req_cycle", 32'(req_at), 32'd2);
    check("w4_refill_pulses", 32'(n_refill), 32'd1);
    check("w4_refill_cycle", 32'(refill_at), 32'd7);
    check("w4_count", 32'(MissCount), 32'd1);
    check("w4_bubble_eq", 32'(n_bub), 32'd0);

    // Ready in the request cycle
    clr();
    miss_fast();
    cyc(1'b1, 1'b1, 1'b0);
    check("fast_stall_cycles", 32'(n_stall), 32'd3);
    check("fast_refill_cycle", 32'(refill_at), 32'd3);
    check("fast_count", 32'(MissCount), 32'd2);

    // Reset in the second wait cycle, then a late ready
    clr();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_mid_stall", 32'(n_stall), 32'd3);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    check("rst_mid_stall_after", 32'(n_stall), 32'd3);
    check("rst_mid_refill", 32'(n_refill), 32'd0);
    check("rst_mid_req", 32'(n_req), 32'd1);
    check("rst_mid_count", 32'(MissCount), 32'd0);

    // Ready on the last allowed wait cycle beats the timeout
    clr();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("edge_refill", 32'(n_refill), 32'd1);
    check("edge_terr", 32'(n_terr), 32'd0);
    check("edge_stall_cycles", 32'(n_stall), 32'd11);

    // Timeout: eight wait cycles without ready
    clr();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0);
    check("to_terr_before", 32'(n_terr), 32'd0);
    clr();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b1);
    check("to_terr_hold", 32'(n_terr), 32'd20);
    check("to_stall_hold", 32'(n_stall), 32'd20);
    check("to_refill", 32'(n_refill), 32'd0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    clr();
    cyc(1'b0, 1'b0, 1'b0);
    check("to_cleared_terr", 32'(n_terr), 32'd0);
    check("to_cleared_stall", 32'(n_stall), 32'd0);
    check("to_cleared_count", 32'(MissCount), 32'd0);

    // Hit then miss after refill, back-to-back miss, then saturation
    miss_fast();
    cyc(1'b1, 1'b1, 1'b0);
    miss_fast();
    check("b2b_count_2", 32'(MissCount), 32'd2);
    miss_fast();
    check("b2b_count_3", 32'(MissCount), 32'd3);
    for (int i = 0; i < 12; i++) miss_fast();
    check("sat_count_15", 32'(MissCount), 32'd15);
    for (int i = 0; i < 2; i++) miss_fast();
    check("sat_count_17", 32'(MissCount), 32'd15);
    clr();
    cyc(1'b1, 1'b1, 1'b0);
    check("sat_final_stall", 32'(n_stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
